// File: rtl/sa4x4_sched_if.sv
// sa4x4_sched_if: load port, job control and edge-feed bundle for sa4x4_sched.
// job_cnt/rej_cnt exist only when SA4X4_SCHED_PERF_EN is defined.
interface sa4x4_sched_if #(
    parameter int DW = 16
);
    logic          ld_en;
    logic          ld_sel;
    logic [1:0]    ld_row;
    logic [1:0]    ld_col;
    logic [DW-1:0] ld_data;
    logic          start;
    logic          busy;
    logic          done;
    logic          res_valid;
    logic          arr_rst;
    logic [DW-1:0] a1, a2, a3, a4;
    logic [DW-1:0] b1, b2, b3, b4;
`ifdef SA4X4_SCHED_PERF_EN
    logic [15:0]   job_cnt;
    logic [15:0]   rej_cnt;
`endif

    modport master (
        output ld_en, ld_sel, ld_row, ld_col, ld_data, start,
        input  busy, done, res_valid, arr_rst, a1, a2, a3, a4, b1, b2, b3, b4
`ifdef SA4X4_SCHED_PERF_EN
        , input job_cnt, rej_cnt
`endif
    );

    modport slave (
        input  ld_en, ld_sel, ld_row, ld_col, ld_data, start,
        output busy, done, res_valid, arr_rst, a1, a2, a3, a4, b1, b2, b3, b4
`ifdef SA4X4_SCHED_PERF_EN
        , output job_cnt, rej_cnt
`endif
    );
endinterface

// File: rtl/sa4x4_sched.sv
// sa4x4_sched: buffers A/B and streams them, diagonally skewed, into a 4x4 output-stationary array.
// Define SA4X4_SCHED_PERF_EN to add the job_cnt/rej_cnt performance counters.
module sa4x4_sched #(
    parameter int DW          = 16,
    parameter int K           = 4,
    parameter int DRAIN_CYC   = 2,
    parameter bit ARR_RST_LVL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    sa4x4_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_e;

    localparam logic [3:0] FEED_LAST  = 4'(3*K-3);
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC-1);

    state_e                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [3:0][3:0][DW-1:0]   a_buf_q, b_buf_q;
    logic [3:0][DW-1:0]        a_q, a_d, b_q, b_d;
    logic                      arr_rst_q, res_valid_q;
    logic                      busy, done, idle, accept;

    assign idle   = state_q == IDLE;
    assign accept = idle && bus.start;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CLEAR;
            CLEAR:   state_d = FEED;
            FEED:    if (cnt_q == FEED_LAST) state_d = (DRAIN_CYC == 0) ? DONE : DRAIN;
            DRAIN:   if (cnt_q == DRAIN_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d == state_q && (state_q == FEED || state_q == DRAIN)) ? cnt_q + 4'd1 : 4'd0;
    end

    always_comb begin
        busy = state_q == CLEAR || state_q == FEED || state_q == DRAIN;
        done = state_q == DONE;
    end

    // Row i of A and column i of B enter i cycles late; k is the operand index for feed cycle cnt_d.
    for (genvar i = 0; i < 4; i++) begin : g_feed
        logic [3:0] k;
        logic       live;
        assign k      = cnt_d - 4'(i);
        assign live   = state_d == FEED && cnt_d >= 4'(i) && k <= 4'd3;
        assign a_d[i] = live ? a_buf_q[i][k[1:0]] : '0;
        assign b_d[i] = live ? b_buf_q[k[1:0]][i] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_buf_q     <= '0;
            b_buf_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            arr_rst_q   <= ARR_RST_LVL;
            res_valid_q <= 1'b0;
        end else begin
            if (idle && bus.ld_en && !bus.ld_sel) a_buf_q[bus.ld_row][bus.ld_col] <= bus.ld_data;
            if (idle && bus.ld_en && bus.ld_sel) b_buf_q[bus.ld_row][bus.ld_col] <= bus.ld_data;
            a_q         <= a_d;
            b_q         <= b_d;
            arr_rst_q   <= (state_d == CLEAR) ? ARR_RST_LVL : ~ARR_RST_LVL;
            res_valid_q <= (state_d == DONE) || (res_valid_q && !accept);
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.res_valid = res_valid_q;
    assign bus.arr_rst   = arr_rst_q;
    assign bus.a1        = a_q[0];
    assign bus.a2        = a_q[1];
    assign bus.a3        = a_q[2];
    assign bus.a4        = a_q[3];
    assign bus.b1        = b_q[0];
    assign bus.b2        = b_q[1];
    assign bus.b3        = b_q[2];
    assign bus.b4        = b_q[3];

`ifdef SA4X4_SCHED_PERF_EN
    logic [15:0] job_cnt_q, rej_cnt_q;
    logic [16:0] rej_sum;

    // A start and a load rejected in the same cycle count as two events.
    assign rej_sum = {1'b0, rej_cnt_q} + 17'(busy & bus.start) + 17'(busy & bus.ld_en);

    always_ff @(posedge clk) begin
        if (!rst) begin
            job_cnt_q <= '0;
            rej_cnt_q <= '0;
        end else begin
            job_cnt_q <= job_cnt_q + 16'(done);
            rej_cnt_q <= rej_sum[16] ? 16'hFFFF : rej_sum[15:0];
        end
    end

    assign bus.job_cnt = job_cnt_q;
    assign bus.rej_cnt = rej_cnt_q;
`endif
endmodule

// File: tb/tb_sa4x4_sched.sv
// tb_sa4x4_sched: randomized bench; a behavioural PE array turns the a*/b* streams into
// c1..c16, which are compared with a plain matrix product of the loaded matrices.
`timescale 1ns/1ps
module tb_sa4x4_sched;
    localparam int DW = 16;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    int     n_cmp = 0;
    int     n_err = 0;
    int     am [4][4];
    int     bm [4][4];
    longint acc [4][4];
    logic [DW-1:0] pa [4][4];
    logic [DW-1:0] pb [4][4];
    logic [DW-1:0] ap [4];
    logic [DW-1:0] bp [4];

    sa4x4_sched_if #(.DW(DW)) bus ();

    sa4x4_sched #(.DW(DW), .K(4), .DRAIN_CYC(2), .ARR_RST_LVL(1'b0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign ap[0] = bus.a1;
    assign ap[1] = bus.a2;
    assign ap[2] = bus.a3;
    assign ap[3] = bus.a4;
    assign bp[0] = bus.b1;
    assign bp[1] = bus.b2;
    assign bp[2] = bus.b3;
    assign bp[3] = bus.b4;

    // Output-stationary PE grid: a moves east, b moves south, each PE accumulates a*b.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (bus.arr_rst == 1'b0) begin
                    acc[i][j] <= 0;
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                end else begin
                    acc[i][j] <= acc[i][j] + longint'(j == 0 ? ap[i] : pa[i][j-1]) * longint'(i == 0 ? bp[j] : pb[i-1][j]);
                    pa[i][j]  <= (j == 0) ? ap[i] : pa[i][j-1];
                    pb[i][j]  <= (i == 0) ? bp[j] : pb[i-1][j];
                end
            end
        end
    end

    function automatic int c_errs();
        int n;
        longint e;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                e = 0;
                for (int k = 0; k < 4; k++) e += longint'(am[i][k]) * longint'(bm[k][j]);
                if (acc[i][j] != e) n++;
            end
        end
        return n;
    endfunction

    task automatic rand_mats();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                am[r][c] = int'($urandom_range(0, 65535));
                bm[r][c] = int'($urandom_range(0, 65535));
            end
        end
    endtask

    task automatic load_mats();
        for (int s = 0; s < 2; s++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    bus.ld_en   = 1'b1;
                    bus.ld_sel  = (s == 1);
                    bus.ld_row  = 2'(r);
                    bus.ld_col  = 2'(c);
                    bus.ld_data = DW'(s == 1 ? bm[r][c] : am[r][c]);
                    @(negedge clk);
                end
            end
        end
        bus.ld_en = 1'b0;
    endtask

    // Pulses start now (caller is in IDLE); optionally re-pulses start (and an A[0][0] write) in cycle inj_k.
    task automatic run_job(input int inj_k, input bit inj_ld, output int lat, output bit busy_ok, output bit rv_ok, output int arr_n);
        lat = -1;
        busy_ok = 1'b1;
        rv_ok = 1'b1;
        arr_n = 0;
        bus.start = 1'b1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            bus.start = (k == inj_k);
            bus.ld_en = inj_ld && (k == inj_k);
            if (k == inj_k) begin
                bus.ld_sel  = 1'b0;
                bus.ld_row  = 2'd0;
                bus.ld_col  = 2'd0;
                bus.ld_data = '1;
            end
            if (bus.arr_rst == 1'b0) arr_n++;
            if (bus.done === 1'b1) lat = k;
            else begin
                if (bus.busy !== 1'b1) busy_ok = 1'b0;
                if (bus.res_valid !== 1'b0) rv_ok = 1'b0;
            end
        end
        bus.start = 1'b0;
        bus.ld_en = 1'b0;
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) n++;
        end
    endtask

    task automatic test_reset();
        int lat, an;
        bit bo, ro;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); end
        n_cmp++; if (bus.arr_rst !== 1'b0) begin n_err++; $display("FAIL rst_arr_rst_low: got %b want 0", bus.arr_rst); end
        n_cmp++; if ({bus.a1, bus.a2, bus.a3, bus.a4, bus.b1, bus.b2, bus.b3, bus.b4} !== '0) begin n_err++; $display("FAIL rst_feed_zero: got %h want 0", {bus.a1, bus.a2, bus.a3, bus.a4, bus.b1, bus.b2, bus.b3, bus.b4}); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.arr_rst !== 1'b1) begin n_err++; $display("FAIL rst_arr_rst_release: got %b want 1", bus.arr_rst); end
        rand_mats();
        load_mats();
        run_job(0, 1'b0, lat, bo, ro, an);
        n_cmp++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_res_valid: got %b want 1", bus.res_valid); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL rst_clears_res_valid: got %b want 0", bus.res_valid); end
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin am[r][c] = 0; bm[r][c] = 0; end
        @(negedge clk);
        run_job(0, 1'b0, lat, bo, ro, an);
        n_cmp++; if (lat !== 14) begin n_err++; $display("FAIL rst_job_latency: got %0d want 14", lat); end
        n_cmp++; if (c_errs() !== 0) begin n_err++; $display("FAIL rst_buffers_cleared: wrong c elements %0d want 0", c_errs()); end
        @(negedge clk);
    endtask

    task automatic test_identity();
        int lat, an;
        bit bo, ro;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin am[r][c] = (r == c) ? 1 : 0; bm[r][c] = 4*r + c + 1; end
        load_mats();
        run_job(0, 1'b0, lat, bo, ro, an);
        n_cmp++; if (lat !== 14) begin n_err++; $display("FAIL ident_latency: got %0d want 14", lat); end
        n_cmp++; if (bo !== 1'b1) begin n_err++; $display("FAIL ident_busy_during_job: got %b want 1", bo); end
        n_cmp++; if (ro !== 1'b1) begin n_err++; $display("FAIL ident_res_valid_low_in_job: got %b want 1", ro); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ident_busy_at_done: got %b want 0", bus.busy); end
        n_cmp++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL ident_res_valid: got %b want 1", bus.res_valid); end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                n_cmp++;
                if (acc[i][j] !== longint'(4*i + j + 1)) begin n_err++; $display("FAIL ident_c%0d: got %0d want %0d", 4*i + j + 1, acc[i][j], 4*i + j + 1); end
            end
        end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL ident_done_one_cycle: got %b want 0", bus.done); end
        n_cmp++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL ident_res_valid_holds: got %b want 1", bus.res_valid); end
    endtask

    task automatic test_skew();
        logic [4*DW-1:0] exp_a;
        int t;
        bit fin;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin am[r][c] = 16*r + c; bm[r][c] = 0; end
        load_mats();
        bus.start = 1'b1;
        fin = 1'b0;
        for (int k = 1; k <= 30 && !fin; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            t = k - 2;
            if (k == 1) begin
                n_cmp++; if (bus.arr_rst !== 1'b0 || {bus.a1, bus.a2, bus.a3, bus.a4} !== '0) begin n_err++; $display("FAIL skew_clear: arr_rst %b a %h want 0/0", bus.arr_rst, {bus.a1, bus.a2, bus.a3, bus.a4}); end
            end
            if (t >= 0 && t <= 9) begin
                exp_a = '0;
                for (int i = 0; i < 4; i++) if (t - i >= 0 && t - i <= 3) exp_a[(3-i)*DW +: DW] = DW'(am[i][t-i]);
                n_cmp++; if ({bus.a1, bus.a2, bus.a3, bus.a4} !== exp_a || bus.arr_rst !== 1'b1) begin n_err++; $display("FAIL skew_feed_t%0d: got a %h arr_rst %b want %h 1", t, {bus.a1, bus.a2, bus.a3, bus.a4}, bus.arr_rst, exp_a); end
            end
            if (t == 3) begin
                n_cmp++; if ({bus.a1, bus.a2, bus.a3, bus.a4} !== 64'h0003_0012_0021_0030) begin n_err++; $display("FAIL skew_t3: got %h want 0003001200210030", {bus.a1, bus.a2, bus.a3, bus.a4}); end
            end
            if (t == 4) begin
                n_cmp++; if (bus.a1 !== 16'h0) begin n_err++; $display("FAIL skew_t4_a1: got %h want 0000", bus.a1); end
            end
            if (t >= 10 && bus.done !== 1'b1) begin
                n_cmp++; if ({bus.a1, bus.a2, bus.a3, bus.a4, bus.b1, bus.b2, bus.b3, bus.b4} !== '0) begin n_err++; $display("FAIL skew_drain_zero: got %h want 0", {bus.a1, bus.a2, bus.a3, bus.a4}); end
            end
            if (bus.done === 1'b1) fin = 1'b1;
        end
        n_cmp++; if (fin !== 1'b1) begin n_err++; $display("FAIL skew_done_timeout: done %b want 1", fin); end
        @(negedge clk);
    endtask

    task automatic test_busy_protect();
        int lat, an, nd;
        bit bo, ro;
        rand_mats();
        am[0][0] = 16'h1234;
        load_mats();
        run_job(4, 1'b1, lat, bo, ro, an);
        n_cmp++; if (lat !== 14) begin n_err++; $display("FAIL busy_latency: got %0d want 14", lat); end
        n_cmp++; if (c_errs() !== 0) begin n_err++; $display("FAIL busy_result: wrong c elements %0d want 0", c_errs()); end
        count_dones(20, nd);
        n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL busy_extra_done: got %0d want 0", nd); end
        run_job(0, 1'b0, lat, bo, ro, an);
        n_cmp++; if (lat !== 14 || c_errs() !== 0) begin n_err++; $display("FAIL busy_buffer_kept: latency %0d wrong c %0d want 14/0", lat, c_errs()); end
        @(negedge clk);
    endtask

    task automatic test_midjob_reset();
        int lat, an, nd;
        bit bo, ro;
        rand_mats();
        load_mats();
        bus.start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.arr_rst !== 1'b0) begin n_err++; $display("FAIL midrst_arr_rst: got %b want 0", bus.arr_rst); end
        n_cmp++; if ({bus.a1, bus.a2, bus.a3, bus.a4, bus.b1, bus.b2, bus.b3, bus.b4} !== '0) begin n_err++; $display("FAIL midrst_feed_zero: got %h want 0", {bus.a1, bus.a2, bus.a3, bus.a4, bus.b1, bus.b2, bus.b3, bus.b4}); end
        count_dones(20, nd);
        n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d want 0", nd); end
        rand_mats();
        load_mats();
        run_job(0, 1'b0, lat, bo, ro, an);
        n_cmp++; if (lat !== 14) begin n_err++; $display("FAIL midrst_restart_latency: got %0d want 14", lat); end
        n_cmp++; if (c_errs() !== 0) begin n_err++; $display("FAIL midrst_restart_result: wrong c elements %0d want 0", c_errs()); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, an, r, c;
        bit bo, ro;
        rand_mats();
        load_mats();
        run_job(0, 1'b0, lat, bo, ro, an);
        n_cmp++; if (lat !== 14 || c_errs() !== 0) begin n_err++; $display("FAIL b2b_job1: latency %0d wrong c %0d want 14/0", lat, c_errs()); end
        @(negedge clk);
        n_cmp++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL b2b_res_valid_idle: got %b want 1", bus.res_valid); end
        r = int'($urandom_range(0, 3));
        c = int'($urandom_range(0, 3));
        bm[r][c] = (bm[r][c] + 1 + int'($urandom_range(0, 100))) & 16'hFFFF;
        bus.ld_en   = 1'b1;
        bus.ld_sel  = 1'b1;
        bus.ld_row  = 2'(r);
        bus.ld_col  = 2'(c);
        bus.ld_data = DW'(bm[r][c]);
        run_job(0, 1'b0, lat, bo, ro, an);
        n_cmp++; if (lat !== 14) begin n_err++; $display("FAIL b2b_job2_latency: got %0d want 14", lat); end
        n_cmp++; if (ro !== 1'b1) begin n_err++; $display("FAIL b2b_res_valid_drops: got %b want 1", ro); end
        n_cmp++; if (an !== 1) begin n_err++; $display("FAIL b2b_arr_rst_pulse: got %0d cycles want 1", an); end
        n_cmp++; if (c_errs() !== 0) begin n_err++; $display("FAIL b2b_job2_result: wrong c elements %0d want 0", c_errs()); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, an;
        bit bo, ro;
        for (int n = 0; n < 4; n++) begin
            rand_mats();
            load_mats();
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
            run_job(0, 1'b0, lat, bo, ro, an);
            n_cmp++; if (lat !== 14 || bo !== 1'b1) begin n_err++; $display("FAIL rand%0d_timing: latency %0d busy_ok %b want 14/1", n, lat, bo); end
            n_cmp++; if (c_errs() !== 0) begin n_err++; $display("FAIL rand%0d_result: wrong c elements %0d want 0", n, c_errs()); end
            @(negedge clk);
        end
    endtask

`ifdef SA4X4_SCHED_PERF_EN
    task automatic test_perf();
        int lat, an;
        bit bo, ro;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.job_cnt !== 16'd0 || bus.rej_cnt !== 16'd0) begin n_err++; $display("FAIL perf_initial: job %0d rej %0d want 0/0", bus.job_cnt, bus.rej_cnt); end
        run_job(5, 1'b0, lat, bo, ro, an);
        @(negedge clk);
        run_job(9, 1'b0, lat, bo, ro, an);
        @(negedge clk);
        run_job(0, 1'b0, lat, bo, ro, an);
        @(negedge clk);
        n_cmp++; if (bus.job_cnt !== 16'd3) begin n_err++; $display("FAIL perf_job_cnt: got %0d want 3", bus.job_cnt); end
        n_cmp++; if (bus.rej_cnt !== 16'd2) begin n_err++; $display("FAIL perf_rej_cnt: got %0d want 2", bus.rej_cnt); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_cmp++; if (bus.job_cnt !== 16'd0 || bus.rej_cnt !== 16'd0) begin n_err++; $display("FAIL perf_reset: job %0d rej %0d want 0/0", bus.job_cnt, bus.rej_cnt); end
        @(negedge clk);
    endtask
`endif

    initial begin
        bus.ld_en   = 1'b0;
        bus.ld_sel  = 1'b0;
        bus.ld_row  = 2'd0;
        bus.ld_col  = 2'd0;
        bus.ld_data = '0;
        bus.start   = 1'b0;
        test_reset();
        test_identity();
        test_skew();
        test_busy_protect();
        test_midjob_reset();
        test_back_to_back();
        test_random();
`ifdef SA4X4_SCHED_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
